window_3x3_gen: RTL

- Upstream neighbour of `filter`. Accepts a raster-order 8-bit pixel stream and keeps two line buffers plus a 3x3 shift window.
- Presents a complete 3x3 neighbourhood on `sw_pixels1..9` (row-major, 5 = centre) with a one-cycle `act` strobe per valid window.
- Emits only interior windows, i.e. no border padding: (IMG_W-2)*(IMG_H-2) windows per frame.
- Fully streaming; no backpressure, because `filter` accepts one window per cycle.

---
 rtl/pix_pkg.sv | 23 ++
 rtl/line_buffer.sv | 27 ++
 rtl/window_3x3_gen.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pix_pkg.sv
// Shared pixel-pipeline definitions: pixel width, counter sizing and the
// row-major 3x3 window position numbering used by window_3x3_gen and filter.
package pix_pkg;

    localparam int PIX_W = 8;

    // Window positions, row-major, 1 = top-left, 5 = centre, 9 = bottom-right
    localparam int WIN_TL = 1;
    localparam int WIN_T  = 2;
    localparam int WIN_TR = 3;
    localparam int WIN_L  = 4;
    localparam int WIN_C  = 5;
    localparam int WIN_R  = 6;
    localparam int WIN_BL = 7;
    localparam int WIN_B  = 8;
    localparam int WIN_BR = 9;

    // Bits needed to count 0..n-1, never less than one
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/line_buffer.sv
// Single-port line memory: combinational read of the addressed entry and a
// synchronous write to the same entry, so a read sees the old contents.
module line_buffer
    import pix_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16,
    localparam int AW   = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    // Contents are not reset: every entry is written before it is read in a frame
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    // Write the new column entry at the end of the cycle
    always_ff @(posedge clk) begin
        if (we_i) mem_q[addr_i] <= wdata_i;
    end

endmodule

// File: rtl/window_3x3_gen.sv
// Raster-stream 3x3 neighbourhood generator. Two line buffers (packed into one
// memory) feed a 3x3 shift window; only interior windows are flagged with act.
module window_3x3_gen
    import pix_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = pix_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [PIX_W-1:0] in_pixel,
    output logic [PIX_W-1:0] sw_pixels1,
    output logic [PIX_W-1:0] sw_pixels2,
    output logic [PIX_W-1:0] sw_pixels3,
    output logic [PIX_W-1:0] sw_pixels4,
    output logic [PIX_W-1:0] sw_pixels5,
    output logic [PIX_W-1:0] sw_pixels6,
    output logic [PIX_W-1:0] sw_pixels7,
    output logic [PIX_W-1:0] sw_pixels8,
    output logic [PIX_W-1:0] sw_pixels9,
    output logic             act,
    output logic             frame_done
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // [row][col], row 0 = top line, col 0 = leftmost (oldest) column
    typedef logic [2:0][2:0][PIX_W-1:0] win_t;

    logic [CW-1:0]    col_q, col_d, cur_col;
    logic [RW-1:0]    row_q, row_d, cur_row;
    logic             acc, fire, last_pos;
    logic [PIX_W-1:0] lb_top, lb_mid;
    win_t             win_q, win_d, out_q;
    logic             act_q, fd_q;

    assign acc = en & in_valid;

    // A start-of-frame pixel is (0,0) regardless of where the counters are
    assign cur_col = in_sof ? '0 : col_q;
    assign cur_row = in_sof ? '0 : row_q;

    assign fire     = acc && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    assign last_pos = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

    // Upper half holds the line before last, lower half the previous line
    line_buffer #(
        .DEPTH (IMG_W),
        .WIDTH (2 * PIX_W)
    ) u_lb (
        .clk     (clk),
        .we_i    (acc),
        .addr_i  (cur_col),
        .wdata_i ({lb_mid, in_pixel}),
        .rdata_o ({lb_top, lb_mid})
    );

    // Next raster position after the current pixel
    always_comb begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
        if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
        end
    end

    // Shift every window row left and bring the new column in on the right
    always_comb begin
        win_d = win_q;
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb_top;
        win_d[1][2] = lb_mid;
        win_d[2][2] = in_pixel;
    end

    // Position counters, window shift and registered output window/strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
            win_q <= '0;
            out_q <= '0;
            act_q <= 1'b0;
            fd_q  <= 1'b0;
        end else begin
            act_q <= fire;
            fd_q  <= fire & last_pos;
            if (acc) begin
                col_q <= col_d;
                row_q <= row_d;
                win_q <= win_d;
            end
            // Outputs only move on a flagged window so they hold otherwise
            if (fire) out_q <= win_d;
        end
    end

    assign sw_pixels1 = out_q[0][0];
    assign sw_pixels2 = out_q[0][1];
    assign sw_pixels3 = out_q[0][2];
    assign sw_pixels4 = out_q[1][0];
    assign sw_pixels5 = out_q[1][1];
    assign sw_pixels6 = out_q[1][2];
    assign sw_pixels7 = out_q[2][0];
    assign sw_pixels8 = out_q[2][1];
    assign sw_pixels9 = out_q[2][2];
    assign act        = act_q;
    assign frame_done = fd_q;

endmodule
